codeword_bit_packer: RTL

- Sits directly downstream of the Golomb-Rice codeword stage.
- Accepts one codeword per handshake: a right-aligned value plus its length in bits. The length may exceed 32; the excess is implicit leading zeros from the unary prefix.
- Packs codewords MSB-first into a contiguous bitstream and emits 32-bit words over a valid/ready interface.
- Supports an explicit flush that zero-pads and marks the final word of a slice.

---
 rtl/codeword_bit_packer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/codeword_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : codeword_bit_packer
// Description : Packs right-aligned variable-length codewords (0..63 bits,
//               bits above 32 are implicit leading zeros) MSB-first into a
//               contiguous bitstream and emits 32-bit words over valid/ready.
//               A flush pulse zero-pads and emits the final word of a slice
//               (out_last), then pulses flush_done.
// Ports       : clk, reset_n (async, active-low)
//               in_valid/in_ready/in_code[31:0]/in_len[6:0] : codeword input
//               flush                                       : slice terminate
//               out_valid/out_ready/out_word[31:0]/out_last  : word output
//               flush_done                                  : flush complete
//               bits_total[CNT_W-1:0]                       : accepted bits
// Revision    : 1.0 - initial release
// ============================================================================
module codeword_bit_packer #(
   parameter int MAX_LEN = 63,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_code,
   input  logic [6:0]       in_len,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_word,
   output logic             out_last,
   output logic             flush_done,
   output logic [CNT_W-1:0] bits_total
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      ZPAD  = 2'd1,
      CODE  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t      r_state;
   logic [63:0] r_acc;     // left-aligned bitstream, bits below r_cnt are zero
   logic [6:0]  r_cnt;
   logic        r_fp;      // flush pending
   logic [31:0] r_code;    // low 32 bits of a long codeword in flight
   logic [6:0]  r_len;

   state_t           w_state;
   logic [63:0]      w_acc;
   logic [6:0]       w_cnt;
   logic             w_fp;
   logic [31:0]      w_code;
   logic [6:0]       w_len;
   logic             w_done;
   logic [CNT_W-1:0] w_total;
   logic             w_take;
   logic             w_accept;
   logic [31:0]      w_mask;

   assign w_take   = out_valid && out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_mask   = (in_len >= 7'd32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << in_len[4:0]) - 32'd1);

   // Next-state computation; every registered output is derived from these
   // next values so out_valid / in_ready line up with the new fill level.
   always_comb begin
      w_state = r_state;
      w_acc   = r_acc;
      w_cnt   = r_cnt;
      w_fp    = r_fp | flush;
      w_code  = r_code;
      w_len   = r_len;
      w_done  = 1'b0;
      w_total = bits_total;

      // Ordinary word taken: drop it from the top of the accumulator.
      if (w_take && !out_last) begin
         w_acc = r_acc << 32;
         w_cnt = r_cnt - 7'd32;
      end

      case (r_state)
         RUN: begin
            if (w_accept) begin
               // Oversized lengths are dropped rather than corrupting state.
               if (in_len <= 7'(MAX_LEN)) begin
                  w_total = bits_total + CNT_W'(in_len);
                  if (in_len <= 7'd32) begin
                     // Left-align the code at bit 63, then slide it below
                     // the bits already held.
                     w_acc = w_acc | (({in_code & w_mask, 32'd0}
                                       << (7'd32 - in_len)) >> w_cnt);
                     w_cnt = w_cnt + in_len;
                  end else begin
                     w_code  = in_code;
                     w_len   = in_len;
                     w_state = ZPAD;
                  end
               end
            end else if (w_fp && (w_cnt < 7'd32)) begin
               if (w_cnt == 7'd0) begin
                  // Nothing buffered: complete the flush immediately.
                  w_done = 1'b1;
                  w_fp   = 1'b0;
               end else begin
                  w_state = FLUSH;
               end
            end
         end
         ZPAD: begin
            // Zero bits need no data, only the fill count advances.
            if (w_cnt < 7'd32) begin
               w_cnt   = w_cnt + (r_len - 7'd32);
               w_state = CODE;
            end
         end
         CODE: begin
            if (w_cnt < 7'd32) begin
               w_acc   = w_acc | ({r_code, 32'd0} >> w_cnt);
               w_cnt   = w_cnt + 7'd32;
               w_state = RUN;
            end
         end
         FLUSH: begin
            if (w_take || (r_cnt == 7'd0)) begin
               w_acc   = 64'd0;
               w_cnt   = 7'd0;
               w_fp    = 1'b0;
               w_done  = 1'b1;
               w_state = RUN;
            end
         end
         default: w_state = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= RUN;
         r_acc      <= 64'd0;
         r_cnt      <= 7'd0;
         r_fp       <= 1'b0;
         r_code     <= 32'd0;
         r_len      <= 7'd0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_word   <= 32'd0;
         out_last   <= 1'b0;
         flush_done <= 1'b0;
         bits_total <= '0;
      end else begin
         r_state    <= w_state;
         r_acc      <= w_acc;
         r_cnt      <= w_cnt;
         r_fp       <= w_fp;
         r_code     <= w_code;
         r_len      <= w_len;
         in_ready   <= (w_state == RUN) && (w_cnt < 7'd32) && !w_fp;
         out_valid  <= (w_cnt >= 7'd32) || ((w_state == FLUSH) && (w_cnt != 7'd0));
         out_word   <= w_acc[63:32];
         out_last   <= (w_state == FLUSH) && (w_cnt != 7'd0) && (w_cnt < 7'd32);
         flush_done <= w_done;
         bits_total <= w_total;
      end
   end

endmodule
`default_nettype wire
